// File: rtl/lp805x_port_mon.sv
// Pass/fail exit-code monitor for self-checking lp805x firmware: glitch-filters
// the core output ports and latches a sticky pass/fail/timeout verdict.
module lp805x_port_mon #(
  parameter int unsigned      WIDTH      = 8,
  parameter int unsigned      CHANNELS   = 1,
  parameter logic [WIDTH-1:0] PASS_CODE  = WIDTH'(127),
  parameter logic [WIDTH-1:0] IDLE_CODE  = WIDTH'(255),
  parameter int unsigned      STABLE_CYC = 2,
  parameter int unsigned      TIMEOUT    = 1000000,
  parameter int unsigned      CNT_W      = 32
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      en_i,
  input  logic                      clr_i,
  input  logic [CHANNELS*WIDTH-1:0] port_i,
  output logic                      done_o,
  output logic                      pass_o,
  output logic                      fail_o,
  output logic                      timeout_o,
  output logic [WIDTH-1:0]          code_o,
  output logic [1:0]                fail_ch_o,
  output logic [CNT_W-1:0]          cycles_o
);

  localparam int unsigned      CW      = $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0]    STABLE  = CW'(STABLE_CYC);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      samp_q [CHANNELS];
  logic [WIDTH-1:0]      samp_d [CHANNELS];
  logic [CW-1:0]         cnt_q  [CHANNELS];
  logic [CW-1:0]         cnt_d  [CHANNELS];
  logic [CHANNELS-1:0]   passed_q, passed_d;
  logic                  done_d, pass_d, fail_d, timeout_d;
  logic [WIDTH-1:0]      code_d;
  logic [1:0]            fail_ch_d;
  logic [CNT_W-1:0]      cycles_d;
  logic [WIDTH-1:0]      cur;
  logic                  changed, qual, fail_hit;

  // Next-state, filter and verdict logic
  always_comb begin
    state_d   = state_q;
    samp_d    = samp_q;
    cnt_d     = cnt_q;
    passed_d  = passed_q;
    done_d    = done_o;
    pass_d    = pass_o;
    fail_d    = fail_o;
    timeout_d = timeout_o;
    code_d    = code_o;
    fail_ch_d = fail_ch_o;
    cycles_d  = cycles_o;
    cur       = '0;
    changed   = 1'b0;
    qual      = 1'b0;
    fail_hit  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (en_i) begin
          state_d  = S_RUN;
          passed_d = '0;
          cycles_d = '0;
          for (int ch = 0; ch < int'(CHANNELS); ch++) cnt_d[ch] = '0;
        end
      end
      S_RUN: begin
        cycles_d = cycles_o + CNT_W'(1);
        for (int ch = 0; ch < int'(CHANNELS); ch++) begin
          cur     = port_i[ch*WIDTH +: WIDTH];
          changed = (cur != samp_q[ch]);
          if (changed) begin
            samp_d[ch] = cur;
            cnt_d[ch]  = CW'(1);
          end else if (cnt_q[ch] != STABLE) begin
            cnt_d[ch] = cnt_q[ch] + CW'(1);
          end
          // Qualify once per stable run: only on the edge the count reaches STABLE
          qual = (cnt_d[ch] == STABLE) && (changed || (cnt_q[ch] != STABLE));
          if (qual && !passed_q[ch] && (cur != IDLE_CODE)) begin
            if (cur == PASS_CODE) begin
              passed_d[ch] = 1'b1;
            end else if (!fail_hit) begin
              fail_hit  = 1'b1;
              code_d    = cur;
              fail_ch_d = 2'(ch);
            end
          end
        end
        if (fail_hit) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          fail_d  = 1'b1;
        end else if (&passed_d) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = 1'b1;
        end else if ((TIMEOUT != 0) && (cycles_o == TO_LAST)) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end
      end
      S_DONE: ;
      default: state_d = S_IDLE;
    endcase

    // Leaving to IDLE clears every reported value
    if (clr_i || ((state_q == S_RUN) && !en_i)) begin
      state_d   = S_IDLE;
      done_d    = 1'b0;
      pass_d    = 1'b0;
      fail_d    = 1'b0;
      timeout_d = 1'b0;
      code_d    = '0;
      fail_ch_d = '0;
      cycles_d  = '0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q   <= S_IDLE;
      for (int ch = 0; ch < int'(CHANNELS); ch++) begin
        samp_q[ch] <= '0;
        cnt_q[ch]  <= '0;
      end
      passed_q  <= '0;
      done_o    <= 1'b0;
      pass_o    <= 1'b0;
      fail_o    <= 1'b0;
      timeout_o <= 1'b0;
      code_o    <= '0;
      fail_ch_o <= '0;
      cycles_o  <= '0;
    end else begin
      state_q   <= state_d;
      samp_q    <= samp_d;
      cnt_q     <= cnt_d;
      passed_q  <= passed_d;
      done_o    <= done_d;
      pass_o    <= pass_d;
      fail_o    <= fail_d;
      timeout_o <= timeout_d;
      code_o    <= code_d;
      fail_ch_o <= fail_ch_d;
      cycles_o  <= cycles_d;
    end
  end

endmodule

// File: tb/tb_lp805x_port_mon.sv
// Bench for lp805x_port_mon: directed scenarios plus randomized stimulus
// against a run-length reference model, on a 1-channel and a 2-channel instance.
module tb_lp805x_port_mon;

  logic        clk = 1'b0;
  logic        rst_n, en, clr;
  logic [7:0]  port_a;
  logic [15:0] port_b;

  logic        a_done, a_pass, a_fail, a_to;
  logic [7:0]  a_code;
  logic [1:0]  a_fch;
  logic [31:0] a_cyc;
  logic        b_done, b_pass, b_fail, b_to;
  logic [7:0]  b_code;
  logic [1:0]  b_fch;
  logic [31:0] b_cyc;

  logic [45:0] obs_a, obs_b;
  assign obs_a = {a_done, a_pass, a_fail, a_to, a_code, a_fch, a_cyc};
  assign obs_b = {b_done, b_pass, b_fail, b_to, b_code, b_fch, b_cyc};

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lp805x_port_mon #(.CHANNELS(1), .STABLE_CYC(2), .TIMEOUT(50)) u_a (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .en_i(en), .clr_i(clr), .port_i(port_a),
    .done_o(a_done), .pass_o(a_pass), .fail_o(a_fail), .timeout_o(a_to),
    .code_o(a_code), .fail_ch_o(a_fch), .cycles_o(a_cyc));

  lp805x_port_mon #(.CHANNELS(2), .STABLE_CYC(1), .TIMEOUT(40)) u_b (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .en_i(en), .clr_i(clr), .port_i(port_b),
    .done_o(b_done), .pass_o(b_pass), .fail_o(b_fail), .timeout_o(b_to),
    .code_o(b_code), .fail_ch_o(b_fch), .cycles_o(b_cyc));

  // Reference model: one slot per instance (0 = u_a, 1 = u_b)
  int          m_st [2];            // 0 idle, 1 run, 2 done
  int          m_run [2][2];        // length of current run of equal samples
  logic [7:0]  m_last [2][2];
  bit          m_passed [2][2];
  bit          m_done [2], m_pass [2], m_fail [2], m_to [2];
  logic [7:0]  m_code [2];
  logic [1:0]  m_fch [2];
  logic [31:0] m_cyc [2];

  function automatic void model_clear(int m);
    m_done[m] = 0; m_pass[m] = 0; m_fail[m] = 0; m_to[m] = 0;
    m_code[m] = '0; m_fch[m] = '0; m_cyc[m] = '0;
  endfunction

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      m_st[m] = 0;
      model_clear(m);
      for (int c = 0; c < 2; c++) begin
        m_run[m][c] = 0; m_passed[m][c] = 0; m_last[m][c] = '0;
      end
    end
  endfunction

  function automatic void model_step(int m, logic en_v, logic clr_v, logic [15:0] pv,
                                     int nch, int stb, int tmo);
    bit         found;
    bit         all;
    logic [7:0] v;
    found = 0;
    if (clr_v) begin
      m_st[m] = 0; model_clear(m);
    end else if (m_st[m] == 0) begin
      if (en_v) begin
        m_st[m] = 1; model_clear(m);
        for (int c = 0; c < 2; c++) begin m_run[m][c] = 0; m_passed[m][c] = 0; end
      end
    end else if (m_st[m] == 1) begin
      if (!en_v) begin
        m_st[m] = 0; model_clear(m);
      end else begin
        m_cyc[m] = m_cyc[m] + 1;
        for (int c = 0; c < nch; c++) begin
          v = pv[c*8 +: 8];
          if (m_run[m][c] > 0 && v == m_last[m][c]) m_run[m][c]++;
          else begin m_run[m][c] = 1; m_last[m][c] = v; end
          if (m_run[m][c] == stb && !m_passed[m][c] && v != 8'hFF) begin
            if (v == 8'h7F) m_passed[m][c] = 1;
            else if (!found) begin found = 1; m_code[m] = v; m_fch[m] = 2'(c); end
          end
        end
        all = 1;
        for (int c = 0; c < nch; c++) all = all & m_passed[m][c];
        if (found) begin m_st[m] = 2; m_done[m] = 1; m_fail[m] = 1; end
        else if (all) begin m_st[m] = 2; m_done[m] = 1; m_pass[m] = 1; end
        else if (tmo != 0 && m_cyc[m] == 32'(tmo)) begin
          m_st[m] = 2; m_done[m] = 1; m_to[m] = 1;
        end
      end
    end
  endfunction

  function automatic logic [45:0] exp_vec(int m);
    return {m_done[m], m_pass[m], m_fail[m], m_to[m], m_code[m], m_fch[m], m_cyc[m]};
  endfunction

  // One clock edge; model advances on the same inputs, outputs sampled 1 ns later
  task automatic tick();
    @(posedge clk);
    model_step(0, en, clr, {8'h00, port_a}, 1, 2, 50);
    model_step(1, en, clr, port_b, 2, 1, 40);
    #1;
  endtask

  task automatic go_idle();
    clr = 1'b1; tick(); clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; en = 1'b0; clr = 1'b0; port_a = 8'hFF; port_b = 16'hFFFF;
    #2 rst_n = 1'b0; model_reset();
    #1;
    n_tests++;
    if (obs_a !== 46'd0) begin n_fail++; $display("FAIL reset_a: got %h want 0", obs_a); end
    n_tests++;
    if (obs_b !== 46'd0) begin n_fail++; $display("FAIL reset_b: got %h want 0", obs_b); end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_pass();
    go_idle();
    port_a = 8'hFF; en = 1'b1; tick();
    repeat (10) tick();
    port_a = 8'h7F; tick();
    n_tests++;
    if (a_done !== 1'b0) begin n_fail++; $display("FAIL pass_early: done=%b want 0", a_done); end
    tick();
    n_tests++;
    if (obs_a !== {4'b1100, 8'h00, 2'd0, 32'd12}) begin
      n_fail++; $display("FAIL pass_verdict: got %h want %h", obs_a, {4'b1100, 8'h00, 2'd0, 32'd12});
    end
    port_a = 8'h05; repeat (3) tick();
    n_tests++;
    if (obs_a !== {4'b1100, 8'h00, 2'd0, 32'd12}) begin
      n_fail++; $display("FAIL pass_hold: got %h want %h", obs_a, {4'b1100, 8'h00, 2'd0, 32'd12});
    end
  endtask

  task automatic test_fail_glitch();
    go_idle();
    port_a = 8'hFF; en = 1'b1; tick();
    repeat (3) tick();
    port_a = 8'h00; tick();
    port_a = 8'hFF; repeat (5) tick();
    n_tests++;
    if (a_done !== 1'b0) begin n_fail++; $display("FAIL glitch_ignored: done=%b want 0", a_done); end
    port_a = 8'h05; tick();
    n_tests++;
    if (a_done !== 1'b0) begin n_fail++; $display("FAIL fail_early: done=%b want 0", a_done); end
    tick();
    n_tests++;
    if (obs_a !== {4'b1010, 8'h05, 2'd0, 32'd11}) begin
      n_fail++; $display("FAIL fail_verdict: got %h want %h", obs_a, {4'b1010, 8'h05, 2'd0, 32'd11});
    end
  endtask

  task automatic test_two_channel();
    go_idle();
    port_b = 16'hFFFF; en = 1'b1; tick();
    for (int e = 1; e <= 20; e++) begin
      port_b[7:0]  = (e >= 10) ? 8'h12 : (e >= 5) ? 8'h7F : 8'hFF;
      port_b[15:8] = (e >= 20) ? 8'h7F : 8'hFF;
      tick();
      if (e == 19) begin
        n_tests++;
        if (b_done !== 1'b0) begin n_fail++; $display("FAIL two_ch_wait: done=%b want 0", b_done); end
      end
    end
    n_tests++;
    if (obs_b !== {4'b1100, 8'h00, 2'd0, 32'd20}) begin
      n_fail++; $display("FAIL two_ch_pass: got %h want %h", obs_b, {4'b1100, 8'h00, 2'd0, 32'd20});
    end
    go_idle();
    port_b = 16'hFFFF; tick();
    port_b = {8'h44, 8'h33}; tick();
    n_tests++;
    if (obs_b !== {4'b1010, 8'h33, 2'd0, 32'd1}) begin
      n_fail++; $display("FAIL two_ch_same_edge: got %h want %h", obs_b, {4'b1010, 8'h33, 2'd0, 32'd1});
    end
    go_idle();
    port_b = 16'hFFFF; tick();
    port_b = {8'h44, 8'hFF}; tick();
    n_tests++;
    if (obs_b !== {4'b1010, 8'h44, 2'd1, 32'd1}) begin
      n_fail++; $display("FAIL two_ch_ch1: got %h want %h", obs_b, {4'b1010, 8'h44, 2'd1, 32'd1});
    end
  endtask

  task automatic test_timeout();
    go_idle();
    port_a = 8'hFF; en = 1'b1; tick();
    repeat (49) tick();
    n_tests++;
    if (a_done !== 1'b0) begin n_fail++; $display("FAIL timeout_early: done=%b want 0", a_done); end
    tick();
    n_tests++;
    if (obs_a !== {4'b1001, 8'h00, 2'd0, 32'd50}) begin
      n_fail++; $display("FAIL timeout_verdict: got %h want %h", obs_a, {4'b1001, 8'h00, 2'd0, 32'd50});
    end
    go_idle();
    port_a = 8'hFF; tick();
    repeat (48) tick();
    port_a = 8'h7F; repeat (2) tick();
    n_tests++;
    if (obs_a !== {4'b1100, 8'h00, 2'd0, 32'd50}) begin
      n_fail++; $display("FAIL pass_beats_timeout: got %h want %h", obs_a, {4'b1100, 8'h00, 2'd0, 32'd50});
    end
  endtask

  task automatic test_reset_mid();
    go_idle();
    port_a = 8'hFF; en = 1'b1; tick();
    repeat (5) tick();
    #1 rst_n = 1'b0; model_reset();
    #1;
    n_tests++;
    if (obs_a !== 46'd0) begin n_fail++; $display("FAIL rst_mid_run: got %h want 0", obs_a); end
    rst_n = 1'b1;
    port_a = 8'h05; tick(); repeat (2) tick();
    n_tests++;
    if (obs_a !== {4'b1010, 8'h05, 2'd0, 32'd2}) begin
      n_fail++; $display("FAIL fail_after_rst: got %h want %h", obs_a, {4'b1010, 8'h05, 2'd0, 32'd2});
    end
    #1 rst_n = 1'b0; model_reset();
    #1;
    n_tests++;
    if (obs_a !== 46'd0) begin n_fail++; $display("FAIL rst_mid_done: got %h want 0", obs_a); end
    rst_n = 1'b1;
  endtask

  task automatic test_clr_rerun();
    go_idle();
    port_a = 8'h05; en = 1'b1; tick(); repeat (2) tick();
    clr = 1'b1; tick();
    n_tests++;
    if (obs_a !== 46'd0) begin n_fail++; $display("FAIL clr_done: got %h want 0", obs_a); end
    clr = 1'b0; port_a = 8'h7F; tick();
    tick();
    n_tests++;
    if (a_done !== 1'b0) begin n_fail++; $display("FAIL rerun_early: done=%b want 0", a_done); end
    tick();
    n_tests++;
    if (obs_a !== {4'b1100, 8'h00, 2'd0, 32'd2}) begin
      n_fail++; $display("FAIL rerun_pass: got %h want %h", obs_a, {4'b1100, 8'h00, 2'd0, 32'd2});
    end
  endtask

  task automatic test_en_drop();
    go_idle();
    port_a = 8'hFF; en = 1'b1; tick();
    repeat (4) tick();
    n_tests++;
    if (a_cyc !== 32'd4) begin n_fail++; $display("FAIL run_cycles: got %0d want 4", a_cyc); end
    en = 1'b0; tick();
    n_tests++;
    if (obs_a !== 46'd0) begin n_fail++; $display("FAIL en_drop: got %h want 0", obs_a); end
    port_a = 8'h7F; en = 1'b1; tick();
    tick();
    n_tests++;
    if (a_done !== 1'b0) begin n_fail++; $display("FAIL reen_early: done=%b want 0", a_done); end
    tick();
    n_tests++;
    if (obs_a !== {4'b1100, 8'h00, 2'd0, 32'd2}) begin
      n_fail++; $display("FAIL reen_pass: got %h want %h", obs_a, {4'b1100, 8'h00, 2'd0, 32'd2});
    end
  endtask

  function automatic logic [7:0] next_val(logic [7:0] prev);
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 6) return prev;
    if (r < 8) return 8'hFF;
    if (r == 8) return 8'h7F;
    return 8'($urandom);
  endfunction

  task automatic test_random();
    #1 rst_n = 1'b0; model_reset();
    #1 rst_n = 1'b1;
    en = 1'b0; clr = 1'b0;
    for (int i = 0; i < 600; i++) begin
      en     = ($urandom_range(0, 19) != 0);
      clr    = ($urandom_range(0, 24) == 0);
      port_a = next_val(port_a);
      port_b = {next_val(port_b[15:8]), next_val(port_b[7:0])};
      tick();
      n_tests++;
      if (obs_a !== exp_vec(0)) begin
        n_fail++; $display("FAIL rand_a cycle %0d: got %h want %h", i, obs_a, exp_vec(0));
      end
      n_tests++;
      if (obs_b !== exp_vec(1)) begin
        n_fail++; $display("FAIL rand_b cycle %0d: got %h want %h", i, obs_b, exp_vec(1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail_glitch();
    test_two_channel();
    test_timeout();
    test_reset_mid();
    test_clr_rerun();
    test_en_drop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
